prog_clock_divider: RTL
=======================

# prog_clock_divider

Programmable integer clock divider that produces a near-50 % duty square wave and a one-cycle period tick at any ratio N from 2 to 2^WIDTH−1. It sits downstream of the fixed power-of-two divider stage in the clocking path and serves consumers that need non-power-of-two rates. The ratio can be reprogrammed at runtime through a valid/ready handshake. A new ratio takes effect only at a period boundary, so the output never glitches. All outputs are registered logic in the `clk` domain; nothing here drives a clock tree directly.

## Interface
- `WIDTH`, default 8: width of the ratio field and of the internal counter.
- `clk` input 1: system clock; all state updates on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `enable` input 1: run request; sampled every edge.
- `div_ratio` input WIDTH: requested division ratio N.
- `ratio_valid` input 1: `div_ratio` is offered this cycle.
- `ratio_ready` output 1: pending slot free; transfer occurs on an edge where `ratio_valid` and `ratio_ready` are both 1.
- `clk_out` output 1: divided square wave.
- `tick` output 1: one-cycle pulse in the last cycle of each period.
- `running` output 1: block is in RUN.

## Operation
- **State:**
  - FSM: IDLE, RUN.
  - Counter `count[WIDTH-1:0]`.
  - Active ratio `n_act` and its high-time `h_act = (n_act+1)>>1`, computed in WIDTH+1 bits so there is no overflow at N = 2^WIDTH−1.
  - Pending ratio `n_pend` with flag `pend`.
- **Ratio sanitising:**
  - An accepted `div_ratio` of 0 or 1 is stored as 2.
  - All other values are stored unchanged.
- **Handshake:**
  - `ratio_ready = !pend`, combinational from a register.
  - An accepted transfer sets `pend` and loads `n_pend`.
  - `div_ratio` is ignored when no transfer occurs.
- **IDLE:**
  - `count` = 0, `clk_out` = 0, `tick` = 0, `running` = 0.
  - If `pend` = 1, the edge copies `n_pend` into `n_act` and clears `pend`.
  - An edge sampling `enable` = 1 moves to RUN with `count` = 0, `clk_out` = 1, and `running` = 1.
- **RUN, each edge with `enable` = 1:**
  - If `count` = `n_act`−1, this is a wrap: `count` goes to 0. If `pend` was 1 before the edge, `n_act` ← `n_pend` and `pend` is cleared.
  - Otherwise `count` increments.
  - Registered outputs are aligned with the new `count`:
    - `clk_out` = (count < h_act), using the `h_act` in force for that period.
    - `tick` = (count = n_act−1).
- **Duty cycle:** `clk_out` is high for ceil(N/2) cycles and low for floor(N/2) cycles. The period is exactly N cycles.
- **Leaving RUN:** an edge sampling `enable` = 0 returns to IDLE, clears `count`, `clk_out` and `tick`, and truncates the current period. A held pending ratio is applied on the following IDLE edge.

## Timing
- **Reset values:** `count` = 0, `n_act` = 2, `pend` = 0, state IDLE. Outputs: `clk_out` = 0, `tick` = 0, `running` = 0, `ratio_ready` = 1.
- **Start latency:** `clk_out` rises on the first edge that samples `enable` = 1. The first period is a full N cycles.
- **Capture and apply are separate steps:**
  - A ratio accepted on a wrap edge does not apply at that wrap. It applies at the next wrap.
  - In IDLE, a ratio applies one edge after acceptance, and `ratio_ready` is low for that one cycle.
- **Back-pressure:** while `pend` = 1, `ratio_ready` stays low.
  - The producer holds `ratio_valid` and `div_ratio`.
  - There is no overwrite and no loss.
- **Wrap and disable on the same edge:** if `enable` falls on a wrap edge, the disable wins and the state goes to IDLE. Any pending ratio is applied in IDLE.
- **Reset mid-operation:** asserting `reset_n` low clears all state immediately, asynchronously, and any pending ratio is discarded. Operation resumes from reset values on the first edge after `reset_n` deasserts.

## Test plan
- **Reset and default ratio:** release reset and hold `enable` = 1 with no ratio writes → `clk_out` toggles 1,0,1,0 (N = 2), `tick` is high on every 2nd cycle, and `running` = 1.
- **Odd ratio:** load 5 in IDLE, then enable → `clk_out` repeats 1,1,1,0,0 and `tick` is high in the 5th cycle of each period.
- **Mid-period change and back-pressure:**
  - Running at N = 8, load 3 at count 2 → the 8-cycle period completes (4 high, 4 low) before switching to 2 high, 1 low.
  - A second `ratio_valid` during this sees `ratio_ready` = 0 until the wrap, then is accepted.
- **Sanitising:** load 0, then separately load 1 → behaviour is identical to N = 2 in both cases.
- **Disable mid-period:** running at N = 6, drop `enable` at count 3 → on the next edge `clk_out` = 0 and `count` = 0. Re-enabling starts a fresh 3-high, 3-low period.
- **Async reset mid-run:** running at N = 7 with a pending ratio of 4, pulse `reset_n` low between edges → outputs clear immediately and, after release with enable, N = 2 runs; the pending 4 is discarded.

Source files
------------

// File: rtl/prog_clock_divider.sv
// Programmable integer clock divider: near-50% duty square wave plus a last-cycle tick.
// New ratios arrive over a valid/ready handshake and only take effect at a period boundary.
module prog_clock_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] div_ratio_i,
    input  logic             ratio_valid_i,
    output logic             ratio_ready_o,
    output logic             clk_out_o,
    output logic             tick_o,
    output logic             running_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam logic [WIDTH-1:0] RATIO_MIN = WIDTH'(2);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] n_act_q, n_act_d;
    logic [WIDTH-1:0] n_pend_q, n_pend_d;
    logic             pend_q, pend_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;

    logic             accept;
    logic             wrap;
    logic [WIDTH-1:0] ratio_san;
    logic [WIDTH:0]   h_next;

    assign accept    = ratio_valid_i & ~pend_q;
    assign ratio_san = (div_ratio_i < RATIO_MIN) ? RATIO_MIN : div_ratio_i;
    assign wrap      = (count_q == (n_act_q - WIDTH'(1)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            n_act_q   <= RATIO_MIN;
            n_pend_q  <= RATIO_MIN;
            pend_q    <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            n_act_q   <= n_act_d;
            n_pend_q  <= n_pend_d;
            pend_q    <= pend_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        n_act_d   = n_act_q;
        n_pend_d  = n_pend_q;
        pend_d    = pend_q;
        clk_out_d = 1'b0;
        tick_d    = 1'b0;

        // A held ratio moves to active on any IDLE edge, or at a wrap while running.
        if (pend_q && ((state_q == S_IDLE) || (enable_i && wrap))) begin
            n_act_d = n_pend_q;
            pend_d  = 1'b0;
        end
        if (accept) begin
            pend_d   = 1'b1;
            n_pend_d = ratio_san;
        end

        h_next = ({1'b0, n_act_d} + (WIDTH+1)'(1)) >> 1;

        case (state_q)
            S_IDLE: begin
                count_d = '0;
                if (enable_i) begin
                    state_d   = S_RUN;
                    clk_out_d = 1'b1;
                end
            end
            S_RUN: begin
                if (enable_i) begin
                    count_d   = wrap ? '0 : (count_q + WIDTH'(1));
                    clk_out_d = ({1'b0, count_d} < h_next);
                    tick_d    = (count_d == (n_act_d - WIDTH'(1)));
                end else begin
                    state_d = S_IDLE;
                    count_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_comb begin
        ratio_ready_o = ~pend_q;
        clk_out_o     = clk_out_q;
        tick_o        = tick_q;
        running_o     = (state_q == S_RUN);
    end

endmodule
